vpe_sat_sequencer: RTL and testbench
====================================

// Module: vpe_sat_sequencer
// PURPOSE
//  Control FSM for one VPE slave column array. Loads clause SRAM rows from a host stream, presets
//  the variable register, then runs evaluate/update iterations until SATISFY or an iteration
//  limit. Drives SRAM_STATE/BL_EN/WL_SIGN/VAR_STATE/V_PRE/VUL_EN/STOCHASTIC_MODE of the slave.
// PARAMETERS
//  NGRP      8      BL_EN groups (4 clause columns each)
//  ITER_W    16     iteration counter width
//  SETTLE    2      evaluate cycles before update (>=1)
// PORTS
//  CLK         in   1       clock
//  RESET_N     in   1       async active-low reset
//  START       in   1       1-cycle pulse: begin LOAD (ignored unless IDLE/DONE)
//  LD_VALID    in   1       host beat valid
//  LD_READY    out  1       sequencer accepts beat
//  LD_GRP      in   3       target BL_EN group of beat
//  LD_SIGN     in   1       WL_SIGN for beat
//  LD_LAST     in   1       final load beat
//  CFG_MAXIT   in   ITER_W  iteration limit (0 = single iteration)
//  CFG_VINIT   in   1       V_PRE value at preset
//  CFG_STOCH   in   1       stochastic-mode request
//  SATISFY     in   1       slave global satisfy
//  SRAM_STATE  out  1       1 = SRAM write, 0 = read/evaluate
//  BL_EN       out  NGRP    one-hot group write enable
//  WL_SIGN     out  1       registered LD_SIGN
//  VAR_STATE   out  1       1 = variable preset
//  V_PRE       out  1       preset value
//  VUL_EN      out  1       variable-update enable
//  STOCHASTIC_MODE out 1    to slave update logic
//  BUSY        out  1       not IDLE/DONE
//  DONE        out  1       level, DONE state
//  SOLVED      out  1       valid with DONE: 1 = satisfied
//  ITER_CNT    out  ITER_W  iterations completed
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; ITER_CNT 0.
//  IDLE/DONE --START--> LOAD; ITER_CNT<=0, SOLVED<=0.
//  LOAD: SRAM_STATE=1, LD_READY=1. Each LD_VALID&LD_READY beat: next cycle BL_EN=onehot(LD_GRP),
//   WL_SIGN=LD_SIGN for exactly 1 cycle (WRITE); LD_READY=0 during WRITE (1 beat per 2 cycles).
//   After beat with LD_LAST's WRITE -> PRESET.
//  PRESET (1 cyc): SRAM_STATE=0, VAR_STATE=1, V_PRE=CFG_VINIT -> EVAL.
//  EVAL (SETTLE cyc, counter): SRAM_STATE=0, all strobes 0. Last EVAL cycle samples SATISFY:
//   1 -> DONE, SOLVED=1; else ITER_CNT==CFG_MAXIT -> DONE, SOLVED=0; else -> UPDATE.
//  UPDATE (1 cyc): VUL_EN=1; ITER_CNT+=1 (saturates at all-ones) -> EVAL.
//  DONE: holds SOLVED/ITER_CNT until next START.
//  START while BUSY ignored. LD_VALID outside LOAD ignored (LD_READY=0).
//  Mid-run RESET_N low: immediate IDLE, all strobes 0 (no partial write committed by FSM).
//  CFG_* sampled at START into shadow regs; later changes have no effect on run.
//  BL_EN and VUL_EN never both nonzero in a cycle; BL_EN only with SRAM_STATE=1.
// CONFIGURATION
//  VPE_SEQ_ANNEAL_EN defined: STOCHASTIC_MODE=CFG_STOCH while ITER_CNT < CFG_MAXIT>>1,
//   then 0 (deterministic descent for second half); 0 outside EVAL/UPDATE.
//  Undefined: STOCHASTIC_MODE = latched CFG_STOCH during EVAL/UPDATE, else 0.
// STRUCTURE
//  Package vpe_seq_pkg: state enum (IDLE,LOAD,WRITE,PRESET,EVAL,UPDATE,DONE), NGRP, ITER_W
//  defaults, onehot-decode function. Single module; no sub-modules.
// TESTING
//  1 Reset mid-EVAL -> all outputs 0, BUSY=0 same cycle as RESET_N low.
//  2 START, 8 beats LD_GRP=0..7 LD_SIGN alternating, LAST on 8th -> BL_EN 0x01..0x80 one-hot
//    1 cyc each, WL_SIGN matches, then VAR_STATE=1 1 cyc with V_PRE=CFG_VINIT.
//  3 SATISFY=1 from start, SETTLE=2 -> DONE 3 cyc after PRESET, SOLVED=1, ITER_CNT=0, no VUL_EN.
//  4 SATISFY=0, CFG_MAXIT=5 -> exactly 5 VUL_EN pulses, DONE SOLVED=0 ITER_CNT=5.
//  5 SATISFY rises after 3rd VUL_EN, MAXIT=100 -> SOLVED=1 ITER_CNT=3; START during run ignored.
//  6 ANNEAL_EN, CFG_STOCH=1, MAXIT=8 -> STOCHASTIC_MODE=1 for ITER_CNT 0..3, 0 for 4..8.

Source files
------------

// File: rtl/vpe_seq_pkg.sv
// vpe_seq_pkg: shared state encoding, size defaults and group decode for the VPE SAT sequencer
package vpe_seq_pkg;
  localparam int NGRP_D = 8;
  localparam int ITER_W_D = 16;
  localparam int SETTLE_D = 2;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LOAD   = 3'd1;
  localparam state_t S_WRITE  = 3'd2;
  localparam state_t S_PRESET = 3'd3;
  localparam state_t S_EVAL   = 3'd4;
  localparam state_t S_UPDATE = 3'd5;
  localparam state_t S_DONE   = 3'd6;
  function automatic logic [31:0] onehot(input logic [4:0] g);
    return 32'd1 << g;
  endfunction
endpackage

// File: rtl/vpe_sat_sequencer.sv
// vpe_sat_sequencer: load/preset/evaluate/update control FSM for one VPE slave column array
// VPE_SEQ_ANNEAL_EN: stochastic mode only during the first half of the iteration budget
import vpe_seq_pkg::*;
module vpe_sat_sequencer #(
  parameter int NGRP = NGRP_D,
  parameter int ITER_W = ITER_W_D,
  parameter int SETTLE = SETTLE_D
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [$clog2(NGRP)-1:0] ld_grp,
  input  logic                    ld_sign,
  input  logic                    ld_last,
  input  logic [ITER_W-1:0]       cfg_maxit,
  input  logic                    cfg_vinit,
  input  logic                    cfg_stoch,
  input  logic                    satisfy,
  output logic                    sram_state,
  output logic [NGRP-1:0]         bl_en,
  output logic                    wl_sign,
  output logic                    var_state,
  output logic                    v_pre,
  output logic                    vul_en,
  output logic                    stochastic_mode,
  output logic                    busy,
  output logic                    done,
  output logic                    solved,
  output logic [ITER_W-1:0]       iter_cnt
);
  localparam int EW = $clog2(SETTLE + 1);
  state_t state;
  logic [EW-1:0] ecnt;
  logic [ITER_W-1:0] maxit_q;
  logic vinit_q, stoch_q, sign_q, last_q;
  logic [$clog2(NGRP)-1:0] grp_q;
  logic ev_last, running;
  assign ev_last = ecnt == EW'(SETTLE - 1);
  assign running = state == S_EVAL || state == S_UPDATE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ecnt <= '0;
      iter_cnt <= '0;
      solved <= 1'b0;
      maxit_q <= '0;
      vinit_q <= 1'b0;
      stoch_q <= 1'b0;
      sign_q <= 1'b0;
      last_q <= 1'b0;
      grp_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          state <= S_LOAD;
          iter_cnt <= '0;
          solved <= 1'b0;
          maxit_q <= cfg_maxit;
          vinit_q <= cfg_vinit;
          stoch_q <= cfg_stoch;
        end
        S_LOAD: if (ld_valid) begin
          state <= S_WRITE;
          grp_q <= ld_grp;
          sign_q <= ld_sign;
          last_q <= ld_last;
        end
        S_WRITE: state <= last_q ? S_PRESET : S_LOAD;
        S_PRESET: begin
          state <= S_EVAL;
          ecnt <= '0;
        end
        S_EVAL: if (!ev_last) ecnt <= ecnt + 1'b1;
          else if (satisfy) begin
            state <= S_DONE;
            solved <= 1'b1;
          end else state <= iter_cnt == maxit_q ? S_DONE : S_UPDATE;
        S_UPDATE: begin
          state <= S_EVAL;
          ecnt <= '0;
          iter_cnt <= iter_cnt + ITER_W'(~&iter_cnt);
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  assign ld_ready = state == S_LOAD;
  assign sram_state = state == S_LOAD || state == S_WRITE;
  assign bl_en = state == S_WRITE ? NGRP'(onehot(5'(grp_q))) : '0;
  assign wl_sign = state == S_WRITE && sign_q;
  assign var_state = state == S_PRESET;
  assign v_pre = state == S_PRESET && vinit_q;
  assign vul_en = state == S_UPDATE;
  assign busy = !(state == S_IDLE || state == S_DONE);
  assign done = state == S_DONE;
`ifdef VPE_SEQ_ANNEAL_EN
  assign stochastic_mode = running && stoch_q && iter_cnt < (maxit_q >> 1);
`else
  assign stochastic_mode = running && stoch_q;
`endif
endmodule

// File: tb/tb_vpe_sat_sequencer.sv
// tb_vpe_sat_sequencer: directed self-checking bench for the VPE SAT sequencer
module tb_vpe_sat_sequencer;
  logic clk = 1'b0;
  logic rst_n, start, ld_valid, ld_sign, ld_last, cfg_vinit, cfg_stoch, satisfy;
  logic [2:0] ld_grp;
  logic [15:0] cfg_maxit;
  logic ld_ready, sram_state, wl_sign, var_state, v_pre, vul_en, stochastic_mode, busy, done, solved;
  logic [7:0] bl_en;
  logic [15:0] iter_cnt;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  vpe_sat_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_grp(ld_grp), .ld_sign(ld_sign), .ld_last(ld_last), .cfg_maxit(cfg_maxit),
    .cfg_vinit(cfg_vinit), .cfg_stoch(cfg_stoch), .satisfy(satisfy), .sram_state(sram_state),
    .bl_en(bl_en), .wl_sign(wl_sign), .var_state(var_state), .v_pre(v_pre), .vul_en(vul_en),
    .stochastic_mode(stochastic_mode), .busy(busy), .done(done), .solved(solved),
    .iter_cnt(iter_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start_run(input logic [15:0] maxit, input logic vinit, input logic stoch);
    cfg_maxit = maxit;
    cfg_vinit = vinit;
    cfg_stoch = stoch;
    start = 1'b1;
    tick;
    start = 1'b0;
    cfg_maxit = 16'hffff;
    cfg_vinit = ~vinit;
    cfg_stoch = ~stoch;
    chk("load_ready", 32'(ld_ready), 1);
    chk("load_sram", 32'(sram_state), 1);
    chk("load_busy", 32'(busy), 1);
    chk("solved_clr", 32'(solved), 0);
    chk("iter_clr", 32'(iter_cnt), 0);
  endtask
  task automatic load(input int n, input logic vinit);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_grp = 3'(i);
      ld_sign = i[0];
      ld_last = i == n - 1;
      tick;
      ld_valid = 1'b0;
      ld_last = 1'b0;
      chk("bl_en", 32'(bl_en), 32'(1) << i);
      chk("wl_sign", 32'(wl_sign), 32'(i % 2));
      chk("wr_ready", 32'(ld_ready), 0);
      tick;
      if (i < n - 1) chk("ld_ready", 32'(ld_ready), 1);
    end
    chk("var_state", 32'(var_state), 1);
    chk("v_pre", 32'(v_pre), 32'(vinit));
    chk("pre_sram", 32'(sram_state), 0);
    chk("pre_bl_en", 32'(bl_en), 0);
  endtask
  task automatic run(input int sat_after, input int poke, output int cyc, output int vul, output int sto);
    int bad;
    cyc = 0;
    vul = 0;
    sto = 0;
    bad = 0;
    satisfy = sat_after == 0;
    while (!done && cyc < 2000) begin
      start = cyc == poke;
      tick;
      cyc++;
      if (!done) begin
        if (stochastic_mode) sto++;
        if (vul_en) vul++;
        if (bl_en != 8'd0 || sram_state || var_state || !busy) bad++;
      end
      satisfy = vul >= sat_after;
    end
    start = 1'b0;
    chk("run_timeout", 32'(cyc >= 2000), 0);
    chk("run_strobes", 32'(bad), 0);
    chk("done_stoch", 32'(stochastic_mode), 0);
    chk("done_busy", 32'(busy), 0);
  endtask
  initial begin
    int cyc, vul, sto;
    rst_n = 1'b0;
    start = 1'b0;
    ld_valid = 1'b0;
    ld_sign = 1'b0;
    ld_last = 1'b0;
    ld_grp = 3'd0;
    cfg_maxit = 16'd0;
    cfg_vinit = 1'b0;
    cfg_stoch = 1'b0;
    satisfy = 1'b0;
    #12;
    chk("rst_ctl", 32'({sram_state, bl_en, wl_sign, var_state, v_pre, vul_en, stochastic_mode, busy, done, solved, ld_ready}), 0);
    chk("rst_iter", 32'(iter_cnt), 0);
    rst_n = 1'b1;
    tick;
    ld_valid = 1'b1;
    tick;
    chk("idle_ready", 32'(ld_ready), 0);
    chk("idle_bl_en", 32'(bl_en), 0);
    chk("idle_busy", 32'(busy), 0);
    ld_valid = 1'b0;
    start_run(16'd7, 1'b1, 1'b0);
    load(8, 1'b1);
    run(0, -1, cyc, vul, sto);
    chk("sat_cyc", 32'(cyc), 3);
    chk("sat_vul", 32'(vul), 0);
    chk("sat_solved", 32'(solved), 1);
    chk("sat_iter", 32'(iter_cnt), 0);
    satisfy = 1'b0;
    tick;
    tick;
    tick;
    chk("hold_done", 32'(done), 1);
    chk("hold_solved", 32'(solved), 1);
    start_run(16'd5, 1'b0, 1'b0);
    load(1, 1'b0);
    run(1000, -1, cyc, vul, sto);
    chk("max_cyc", 32'(cyc), 18);
    chk("max_vul", 32'(vul), 5);
    chk("max_solved", 32'(solved), 0);
    chk("max_iter", 32'(iter_cnt), 5);
    chk("max_sto", 32'(sto), 0);
    start_run(16'd0, 1'b1, 1'b1);
    load(2, 1'b1);
    run(1000, -1, cyc, vul, sto);
    chk("zero_cyc", 32'(cyc), 3);
    chk("zero_vul", 32'(vul), 0);
    chk("zero_iter", 32'(iter_cnt), 0);
`ifdef VPE_SEQ_ANNEAL_EN
    chk("zero_sto", 32'(sto), 0);
`else
    chk("zero_sto", 32'(sto), 2);
`endif
    start_run(16'd100, 1'b0, 1'b0);
    load(1, 1'b0);
    run(3, 4, cyc, vul, sto);
    chk("late_cyc", 32'(cyc), 12);
    chk("late_vul", 32'(vul), 3);
    chk("late_solved", 32'(solved), 1);
    chk("late_iter", 32'(iter_cnt), 3);
    start_run(16'd8, 1'b0, 1'b1);
    load(1, 1'b0);
    run(1000, -1, cyc, vul, sto);
    chk("stoch_cyc", 32'(cyc), 27);
    chk("stoch_iter", 32'(iter_cnt), 8);
`ifdef VPE_SEQ_ANNEAL_EN
    chk("stoch_cnt", 32'(sto), 12);
`else
    chk("stoch_cnt", 32'(sto), 26);
`endif
    start_run(16'd100, 1'b0, 1'b1);
    load(1, 1'b0);
    satisfy = 1'b0;
    tick;
    tick;
    chk("pre_rst_sto", 32'(stochastic_mode), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 32'({sram_state, bl_en, wl_sign, var_state, v_pre, vul_en, stochastic_mode, busy, done, solved, ld_ready}), 0);
    chk("mid_rst_iter", 32'(iter_cnt), 0);
    #10;
    rst_n = 1'b1;
    tick;
    chk("post_rst_busy", 32'(busy), 0);
    start_run(16'd0, 1'b1, 1'b0);
    load(1, 1'b1);
    run(0, -1, cyc, vul, sto);
    chk("recover_cyc", 32'(cyc), 3);
    chk("recover_solved", 32'(solved), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
